// File: rtl/cmp_pipe_if.sv
// Handshake bundle for cmp_pipe: operand pair in, one registered compare result out.
interface cmp_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, out, gt, eq, lt
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, out, gt, eq, lt
    );
endinterface

// File: rtl/cmp_pipe.sv
// Single-stage signed/unsigned comparator with a one-entry output register
// and running min/max/equality statistics over accepted pairs.
module cmp_pipe #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_pipe_if.slave        bus,
    input  logic             clear,
    output logic [WIDTH-1:0] run_max,
    output logic [WIDTH-1:0] run_min,
    output logic [CNT_W-1:0] eq_cnt
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             a_gt_b;
    logic             a_eq_b;
    logic [WIDTH-1:0] max_ab;
    logic [WIDTH-1:0] min_ab;
    logic [WIDTH-1:0] new_max;
    logic [WIDTH-1:0] new_min;
    logic             seen;

    // Sign-extend by one bit so one signed compare serves both modes.
    function automatic logic greater(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic             sm);
        logic signed [WIDTH:0] xe;
        logic signed [WIDTH:0] ye;
        xe = {sm & x[WIDTH-1], x};
        ye = {sm & y[WIDTH-1], y};
        return xe > ye;
    endfunction

    assign bus.out_valid = (state == FULL);
    assign bus.in_ready  = (state == EMPTY || bus.out_ready) && rst_n;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        a_gt_b  = greater(bus.a, bus.b, bus.signed_mode);
        a_eq_b  = (bus.a == bus.b);
        max_ab  = a_gt_b ? bus.a : bus.b;
        min_ab  = a_gt_b ? bus.b : bus.a;
        new_max = max_ab;
        new_min = min_ab;
        // A clear on the accepting edge makes this pair the first sample.
        if (seen && !clear) begin
            if (greater(run_max, max_ab, bus.signed_mode)) begin
                new_max = run_max;
            end
            if (greater(min_ab, run_min, bus.signed_mode)) begin
                new_min = run_min;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_next = FULL;
                end else if (bus.out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out <= 8'h00;
            bus.gt  <= 1'b0;
            bus.eq  <= 1'b0;
            bus.lt  <= 1'b0;
        end else if (accept) begin
            bus.out <= a_gt_b ? 8'h3E : (a_eq_b ? 8'h3D : 8'h3C);
            bus.gt  <= a_gt_b;
            bus.eq  <= a_eq_b;
            bus.lt  <= !a_gt_b && !a_eq_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_max <= '0;
            run_min <= '0;
            eq_cnt  <= '0;
            seen    <= 1'b0;
        end else if (accept) begin
            run_max <= new_max;
            run_min <= new_min;
            seen    <= 1'b1;
            if (clear) begin
                eq_cnt <= CNT_W'(a_eq_b);
            end else if (a_eq_b && eq_cnt != '1) begin
                eq_cnt <= eq_cnt + CNT_W'(1);
            end
        end else if (clear) begin
            run_max <= '0;
            run_min <= '0;
            eq_cnt  <= '0;
            seen    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cmp_pipe.sv
// Randomized scoreboard bench for cmp_pipe (WIDTH=4, CNT_W=2) with an
// arithmetic reference model of the compare result and running statistics.
module tb_cmp_pipe;
    localparam int WIDTH   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [7:0] code;
        logic       gt;
        logic       eq;
        logic       lt;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic [WIDTH-1:0] run_max;
    logic [WIDTH-1:0] run_min;
    logic [CNT_W-1:0] eq_cnt;

    cmp_pipe_if #(.WIDTH(WIDTH)) dut_bus ();

    cmp_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (dut_bus.slave),
        .clear   (clear),
        .run_max (run_max),
        .run_min (run_min),
        .eq_cnt  (eq_cnt)
    );

    int   n_vec = 0;
    int   n_err = 0;
    res_t exp_q[$];

    bit         m_full = 0;
    bit         m_seen = 0;
    bit         m_after_reset = 0;
    logic [3:0] m_max = '0;
    logic [3:0] m_min = '0;
    int         m_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int value_of(input logic [3:0] x, input bit sm);
        return (sm && x >= 8) ? int'(x) - 16 : int'(x);
    endfunction

    // Monitor: the head of the queue is the result the DUT should be presenting.
    always @(negedge clk) begin
        if (rst_n && dut_bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("[TB] FAIL unexpected_result: got out=0x%0h, expected no result", dut_bus.out);
            end else begin
                check_val("result", {21'd0, dut_bus.out, dut_bus.gt, dut_bus.eq, dut_bus.lt}, {21'd0, exp_q[0]});
                if (dut_bus.out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic check_output(input bit exp_ready);
        check_val("in_ready", {31'd0, dut_bus.in_ready}, {31'd0, exp_ready});
        check_val("out_valid", {31'd0, dut_bus.out_valid}, {31'd0, m_full});
        check_val("run_max", {28'd0, run_max}, {28'd0, m_max});
        check_val("run_min", {28'd0, run_min}, {28'd0, m_min});
        check_val("eq_cnt", {30'd0, eq_cnt}, m_cnt);
        if (m_after_reset) begin
            check_val("reset_out", {21'd0, dut_bus.out, dut_bus.gt, dut_bus.eq, dut_bus.lt}, 32'd0);
            m_after_reset = 0;
        end
    endtask

    task automatic apply_stimulus(input bit v, input logic [3:0] ta, input logic [3:0] tb,
                                  input bit sm, input bit ordy, input bit clr, input bit rstn);
        bit   exp_ready;
        bit   acc;
        int   va, vb, cur;
        res_t r;
        @(posedge clk);
        #1;
        dut_bus.in_valid    = v;
        dut_bus.a           = ta;
        dut_bus.b           = tb;
        dut_bus.signed_mode = sm;
        dut_bus.out_ready   = ordy;
        clear               = clr;
        rst_n               = rstn;
        @(negedge clk);
        exp_ready = (!m_full || ordy) && rstn;
        check_output(exp_ready);
        if (!rstn) begin
            m_full = 0;
            m_seen = 0;
            m_max  = '0;
            m_min  = '0;
            m_cnt  = 0;
            m_after_reset = 1;
            exp_q.delete();
        end else begin
            acc = v && exp_ready;
            if (acc) begin
                va = value_of(ta, sm);
                vb = value_of(tb, sm);
                r.code = (va > vb) ? 8'h3E : ((va == vb) ? 8'h3D : 8'h3C);
                r.gt   = (va > vb);
                r.eq   = (va == vb);
                r.lt   = (va < vb);
                exp_q.push_back(r);
                if (clr || !m_seen) begin
                    m_max = (va >= vb) ? ta : tb;
                    m_min = (va <= vb) ? ta : tb;
                end else begin
                    cur = value_of(m_max, sm);
                    if (va > cur) begin m_max = ta; cur = va; end
                    if (vb > cur) m_max = tb;
                    cur = value_of(m_min, sm);
                    if (va < cur) begin m_min = ta; cur = va; end
                    if (vb < cur) m_min = tb;
                end
                if (clr) m_cnt = (ta == tb) ? 1 : 0;
                else if (ta == tb && m_cnt < CNT_MAX) m_cnt++;
                m_seen = 1;
                m_full = 1;
            end else begin
                if (clr) begin
                    m_max  = '0;
                    m_min  = '0;
                    m_cnt  = 0;
                    m_seen = 0;
                end
                if (ordy) m_full = 0;
            end
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        clear               = 1'b0;
        dut_bus.in_valid    = 1'b0;
        dut_bus.a           = '0;
        dut_bus.b           = '0;
        dut_bus.signed_mode = 1'b0;
        dut_bus.out_ready   = 1'b0;

        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);

        // Basic unsigned ordering, then mode dependence of the same bit pattern.
        apply_stimulus(1, 4'd2, 4'd1, 0, 1, 0, 1);
        apply_stimulus(1, 4'd1, 4'd1, 0, 1, 0, 1);
        apply_stimulus(1, 4'd1, 4'd3, 0, 1, 0, 1);
        apply_stimulus(1, 4'hF, 4'd1, 1, 1, 0, 1);
        apply_stimulus(1, 4'hF, 4'd1, 0, 1, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0, 1);

        // Backpressure holds the result and stalls the next pair.
        apply_stimulus(1, 4'd2, 4'd1, 0, 0, 0, 1);
        apply_stimulus(1, 4'd1, 4'd3, 0, 0, 0, 1);
        apply_stimulus(1, 4'd1, 4'd3, 0, 0, 0, 1);
        apply_stimulus(1, 4'd1, 4'd3, 0, 1, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0, 1);
        check_val("bp_out", {24'd0, dut_bus.out}, 32'h3C);

        // Saturation, statistics and clear coincident with an accept.
        apply_stimulus(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 4'd5, 4'd5, 0, 1, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0, 1);
        check_val("sat_cnt", {30'd0, eq_cnt}, 32'd3);
        apply_stimulus(1, 4'd9, 4'd2, 0, 1, 0, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0, 1);
        check_val("stat_max", {28'd0, run_max}, 32'd9);
        check_val("stat_min", {28'd0, run_min}, 32'd2);
        apply_stimulus(1, 4'd4, 4'd4, 0, 1, 1, 1);
        apply_stimulus(0, 0, 0, 0, 1, 0, 1);
        check_val("clr_max", {28'd0, run_max}, 32'd4);
        check_val("clr_min", {28'd0, run_min}, 32'd4);
        check_val("clr_cnt", {30'd0, eq_cnt}, 32'd1);

        // Reset while a result is pending.
        apply_stimulus(1, 4'd2, 4'd1, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        check_val("rst_valid", {31'd0, dut_bus.out_valid}, 32'd0);
        check_val("rst_ready", {31'd0, dut_bus.in_ready}, 32'd1);

        for (int i = 0; i < 800; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom),
                           1'($urandom), $urandom_range(0, 3) != 0,
                           $urandom_range(0, 19) == 0, $urandom_range(0, 99) != 0);
        end

        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0, 0, 1, 0, 1);
        check_val("drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
